// File: rtl/commu_pkg.sv
// Shared types and constants for the TDMA transmit scheduler: state encoding,
// cfg_bus encodings and counter widths.
package commu_pkg;

    localparam int GUARD_W = 8;
    localparam int WDOG_W  = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_SLOT = 3'd1,
        LEAD      = 3'd2,
        HEAD      = 3'd3,
        PUSH      = 3'd4,
        TAIL      = 3'd5,
        LAG       = 3'd6,
        NEXT      = 3'd7
    } state_t;

    localparam logic [1:0] BUS_NONE = 2'b00;
    localparam logic [1:0] BUS_A    = 2'b01;
    localparam logic [1:0] BUS_B    = 2'b10;
    localparam logic [1:0] BUS_AB   = 2'b11;

    function automatic logic is_phase(state_t s);
        return (s == HEAD) || (s == PUSH) || (s == TAIL);
    endfunction

    function automatic logic drives_bus(state_t s);
        return s inside {LEAD, HEAD, PUSH, TAIL, LAG};
    endfunction

endpackage

// File: rtl/commu_txsched_if.sv
// Phase handshake between the scheduler (master) and the frame engine (slave):
// 1-cycle fire pulses out, 1-cycle done pulses back.
interface commu_txsched_if;
    logic fire_head;
    logic fire_push;
    logic fire_tail;
    logic done_head;
    logic done_push;
    logic done_tail;

    modport master (
        output fire_head, fire_push, fire_tail,
        input  done_head, done_push, done_tail
    );

    modport slave (
        input  fire_head, fire_push, fire_tail,
        output done_head, done_push, done_tail
    );
endinterface

// File: rtl/commu_txsched_cnt.sv
// Guard down-counter (LEAD/LAG) and per-phase watchdog down-counter.
// The watchdog exists only when COMMU_WDOG_EN is defined.
module commu_txsched_cnt
    import commu_pkg::*;
(
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic               guard_load,
    input  logic [GUARD_W-1:0] guard_val,
    input  logic               guard_run,
    output logic               guard_expire,
    input  logic               wdog_load,
    input  logic [WDOG_W-1:0]  wdog_lim,
    input  logic               wdog_run,
    output logic               wdog_expire
);

    logic [GUARD_W-1:0] guard_cnt;

    // A guard of 0 still yields one cycle, so 0 and 1 both load 0.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            guard_cnt <= '0;
        end else if (guard_load) begin
            guard_cnt <= (guard_val == '0) ? '0 : guard_val - GUARD_W'(1);
        end else if (guard_run && (guard_cnt != '0)) begin
            guard_cnt <= guard_cnt - GUARD_W'(1);
        end
    end

    assign guard_expire = (guard_cnt == '0);

`ifdef COMMU_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_en;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
            wdog_en  <= 1'b0;
        end else if (wdog_load) begin
            wdog_cnt <= wdog_lim - WDOG_W'(1);
            wdog_en  <= (wdog_lim != '0);
        end else if (wdog_run && (wdog_cnt != '0)) begin
            wdog_cnt <= wdog_cnt - WDOG_W'(1);
        end
    end

    assign wdog_expire = wdog_en && (wdog_cnt == '0);
`else
    logic wdog_unused;
    assign wdog_unused = ^{wdog_load, wdog_lim, wdog_run};
    assign wdog_expire = 1'b0;
`endif

endmodule

// File: rtl/commu_txsched.sv
// TDMA transmit scheduler: sequences driver enables and head/push/tail phases
// on bus A and/or B. Optional per-phase watchdog: define COMMU_WDOG_EN.
//
// state     | meaning
// IDLE      | no frame pending
// WAIT_SLOT | frame accepted, waiting for slot_open
// LEAD      | DE asserted, lead guard running
// HEAD      | header phase in progress
// PUSH      | payload phase in progress
// TAIL      | trailer phase in progress
// LAG       | DE held, lag guard running
// NEXT      | one idle cycle switching routing from A to B
module commu_txsched
    import commu_pkg::*;
(
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic               frm_start,
    input  logic               slot_open,
    input  logic [1:0]         cfg_bus,
    input  logic [GUARD_W-1:0] guard_cyc,
    input  logic [WDOG_W-1:0]  wdog_lim,
    commu_txsched_if.master    phase,
    output logic               de_a,
    output logic               de_b,
    output logic               sel_b,
    output logic               busy,
    output logic               err_miss,
    output logic               err_wdog
);

    state_t             state_q, state_d;
    logic               entry_q;
    logic               abort_q;
    logic               sel_b_q;
    logic [1:0]         cfg_q;
    logic [GUARD_W-1:0] guard_q;

    logic guard_expire, wdog_expire;
    logic phase_done, slot_drop, wdog_hit, abort_any;

    commu_txsched_cnt u_cnt (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .guard_load   ((state_d == LEAD || state_d == LAG) && (state_d != state_q)),
        .guard_val    (guard_q),
        .guard_run    (state_q == LEAD || state_q == LAG),
        .guard_expire (guard_expire),
        .wdog_load    (is_phase(state_d) && (state_d != state_q)),
        .wdog_lim     (wdog_lim),
        .wdog_run     (is_phase(state_q)),
        .wdog_expire  (wdog_expire)
    );

    always_comb begin
        phase_done = 1'b0;
        case (state_q)
            HEAD:    phase_done = phase.done_head;
            PUSH:    phase_done = phase.done_push;
            TAIL:    phase_done = phase.done_tail;
            default: phase_done = 1'b0;
        endcase
    end

    // Slot loss is reported once; abort_q then carries it to the end of the frame.
    assign slot_drop = (state_q inside {LEAD, HEAD, PUSH, TAIL}) && !slot_open && !abort_q;
    assign wdog_hit  = is_phase(state_q) && wdog_expire && !phase_done;
    assign abort_any = abort_q || slot_drop;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q <= IDLE;
            entry_q <= 1'b0;
            abort_q <= 1'b0;
            sel_b_q <= 1'b0;
            cfg_q   <= BUS_NONE;
            guard_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= (state_d != state_q);
            if (state_q == IDLE && state_d == WAIT_SLOT) begin
                cfg_q   <= cfg_bus;
                guard_q <= guard_cyc;
                sel_b_q <= ~cfg_bus[0];
                abort_q <= 1'b0;
            end else if (state_d == NEXT) begin
                sel_b_q <= 1'b1;
            end
            if (slot_drop || wdog_hit) begin
                abort_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (frm_start && cfg_bus != BUS_NONE) state_d = WAIT_SLOT;
            WAIT_SLOT: if (slot_open) state_d = LEAD;
            LEAD:      if (guard_expire) state_d = abort_any ? LAG : HEAD;
            HEAD: begin
                if (phase_done)    state_d = abort_any ? LAG : PUSH;
                else if (wdog_hit) state_d = LAG;
            end
            PUSH: begin
                if (phase_done)    state_d = abort_any ? LAG : TAIL;
                else if (wdog_hit) state_d = LAG;
            end
            TAIL:      if (phase_done || wdog_hit) state_d = LAG;
            LAG: begin
                if (guard_expire)
                    state_d = (cfg_q == BUS_AB && !sel_b_q && !abort_q) ? NEXT : IDLE;
            end
            NEXT:      state_d = LEAD;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        phase.fire_head = entry_q && (state_q == HEAD);
        phase.fire_push = entry_q && (state_q == PUSH);
        phase.fire_tail = entry_q && (state_q == TAIL);
        de_a            = drives_bus(state_q) && !sel_b_q;
        de_b            = drives_bus(state_q) && sel_b_q;
        sel_b           = sel_b_q;
        busy            = (state_q != IDLE);
        err_miss        = ((state_q != IDLE) && frm_start) || slot_drop;
        err_wdog        = wdog_hit;
    end

endmodule

// File: tb/tb_commu_txsched.sv
// Self-checking bench for commu_txsched: table of frame vectors scored per frame
// through a queue, plus hand sequences for slot wait, miss, slot loss, watchdog, reset.
module tb_commu_txsched;
    import commu_pkg::*;

    typedef struct {
        logic [1:0] cfg;
        int guard;
        int delay;
        int exp_de_a;
        int exp_de_b;
        int exp_fh;
        int exp_fp;
        int exp_ft;
        int exp_busy;
        int exp_miss;
        int exp_wdog;
    } vec_t;

    logic        clk_sys   = 1'b0;
    logic        rst_n     = 1'b0;
    logic        frm_start = 1'b0;
    logic        slot_open = 1'b0;
    logic [1:0]  cfg_bus   = 2'b00;
    logic [7:0]  guard_cyc = 8'd0;
    logic [15:0] wdog_lim  = 16'd0;
    logic        de_a, de_b, sel_b, busy, err_miss, err_wdog;

    commu_txsched_if phase_if();

    commu_txsched dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .frm_start (frm_start),
        .slot_open (slot_open),
        .cfg_bus   (cfg_bus),
        .guard_cyc (guard_cyc),
        .wdog_lim  (wdog_lim),
        .phase     (phase_if),
        .de_a      (de_a),
        .de_b      (de_b),
        .sel_b     (sel_b),
        .busy      (busy),
        .err_miss  (err_miss),
        .err_wdog  (err_wdog)
    );

    always #5 clk_sys = ~clk_sys;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    vec_t sb[$];
    vec_t e_mon;
    int   resp_delay = 1;
    bit   hold_push = 1'b0;
    int   due_h = -1, due_p = -1, due_t = -1;
    int   fr_de_a = 0, fr_de_b = 0, fr_fh = 0, fr_fp = 0, fr_ft = 0;
    int   fr_busy = 0, fr_miss = 0, fr_wdog = 0;
    int   push_cyc = 0, wdog_cyc = 0;
    int   ovl = 0, selbad = 0;
    logic busy_prev = 1'b0, sel_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk_sys);
        cyc = cyc + 1;
    end

    // Phase engine model: done_x comes resp_delay cycles after fire_x; delay 0 holds all done high.
    initial begin
        phase_if.done_head = 1'b0;
        phase_if.done_push = 1'b0;
        phase_if.done_tail = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            phase_if.done_head = (resp_delay == 0) || (cyc == due_h);
            phase_if.done_push = !hold_push && ((resp_delay == 0) || (cyc == due_p));
            phase_if.done_tail = (resp_delay == 0) || (cyc == due_t);
        end
    end

    // Monitor: per-frame accumulation, invariants, scoreboard pop at frame end.
    initial forever begin
        @(negedge clk_sys);
        if (!rst_n) begin
            due_h = -1;
            due_p = -1;
            due_t = -1;
        end
        if (busy && !busy_prev) begin
            fr_de_a = 0; fr_de_b = 0; fr_fh = 0; fr_fp = 0; fr_ft = 0;
            fr_busy = 0; fr_miss = 0; fr_wdog = 0;
        end
        if (de_a)     fr_de_a++;
        if (de_b)     fr_de_b++;
        if (busy)     fr_busy++;
        if (err_miss) fr_miss++;
        if (err_wdog) begin
            fr_wdog++;
            wdog_cyc = cyc;
        end
        if (phase_if.fire_head) begin
            fr_fh++;
            due_h = cyc + resp_delay;
        end
        if (phase_if.fire_push) begin
            fr_fp++;
            due_p = cyc + resp_delay;
            push_cyc = cyc;
        end
        if (phase_if.fire_tail) begin
            fr_ft++;
            due_t = cyc + resp_delay;
        end
        if (de_a && de_b) ovl++;
        if ((sel_b != sel_prev) && (de_a || de_b)) selbad++;
        if (!busy && busy_prev && sb.size() > 0) begin
            e_mon = sb.pop_front();
            chk("de_a_cycles", fr_de_a, e_mon.exp_de_a);
            chk("de_b_cycles", fr_de_b, e_mon.exp_de_b);
            chk("fire_head_cnt", fr_fh, e_mon.exp_fh);
            chk("fire_push_cnt", fr_fp, e_mon.exp_fp);
            chk("fire_tail_cnt", fr_ft, e_mon.exp_ft);
            chk("busy_cycles", fr_busy, e_mon.exp_busy);
            chk("err_miss_cnt", fr_miss, e_mon.exp_miss);
            chk("err_wdog_cnt", fr_wdog, e_mon.exp_wdog);
        end
        busy_prev = busy;
        sel_prev  = sel_b;
    end

    task automatic launch(input vec_t v, input bit score);
        @(posedge clk_sys);
        #1;
        cfg_bus    = v.cfg;
        guard_cyc  = 8'(v.guard);
        resp_delay = v.delay;
        if (score) sb.push_back(v);
        frm_start  = 1'b1;
        @(posedge clk_sys);
        #1;
        frm_start  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_sys);
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, int'(seen), 1);
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_fire(input int which, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_sys);
            if ((which == 0 && phase_if.fire_head) || (which == 1 && phase_if.fire_push)) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, int'(seen), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[7];
        vec_t v;
        tbl[0] = '{2'b01,   4, 10,  41,   0, 1, 1, 1,   42, 0, 0};
        tbl[1] = '{2'b10,   2,  3,   0,  16, 1, 1, 1,   17, 0, 0};
        tbl[2] = '{2'b11,   1,  1,   8,   8, 2, 2, 2,   18, 0, 0};
        tbl[3] = '{2'b11,   0,  0,   5,   5, 2, 2, 2,   12, 0, 0};
        tbl[4] = '{2'b01,   0,  2,  11,   0, 1, 1, 1,   12, 0, 0};
        tbl[5] = '{2'b00,   3,  1,   0,   0, 0, 0, 0,    0, 0, 0};
        tbl[6] = '{2'b11, 255,  0, 513, 513, 2, 2, 2, 1028, 0, 0};

        rst_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("reset_outputs", int'({phase_if.fire_head, phase_if.fire_push, phase_if.fire_tail,
                                   de_a, de_b, sel_b, busy, err_miss, err_wdog}), 0);
        @(posedge clk_sys);
        #1;
        rst_n     = 1'b1;
        slot_open = 1'b1;

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].exp_busy == 0) begin
                launch(tbl[i], 1'b0);
                repeat (3) @(negedge clk_sys);
                chk("disabled_busy", int'(busy), 0);
                @(posedge clk_sys);
                #1;
            end else begin
                launch(tbl[i], 1'b1);
                wait_idle("table_idle");
            end
        end

        // Slot held closed for 50 cycles: no progress, then LEAD one cycle after it opens.
        slot_open = 1'b0;
        v = '{2'b01, 2, 1, 10, 0, 1, 1, 1, 61, 0, 0};
        launch(v, 1'b1);
        repeat (50) @(negedge clk_sys);
        chk("wait_slot_busy", int'(busy), 1);
        chk("wait_slot_nofire", fr_fh, 0);
        chk("wait_slot_de", fr_de_a, 0);
        @(posedge clk_sys);
        #1;
        slot_open = 1'b1;
        @(negedge clk_sys);
        chk("slot_rise_de_same", int'(de_a), 0);
        @(negedge clk_sys);
        chk("slot_rise_de_next", int'(de_a), 1);
        wait_idle("wait_slot_idle");

        // Second start during PUSH plus config changes: frame unchanged, one err_miss.
        v = '{2'b01, 2, 5, 22, 0, 1, 1, 1, 23, 1, 0};
        launch(v, 1'b1);
        wait_fire(1, "miss_wait_push");
        @(posedge clk_sys);
        #1;
        frm_start = 1'b1;
        cfg_bus   = 2'b10;
        guard_cyc = 8'd9;
        @(negedge clk_sys);
        chk("miss_pulse", int'(err_miss), 1);
        @(posedge clk_sys);
        #1;
        frm_start = 1'b0;
        @(negedge clk_sys);
        chk("miss_pulse_end", int'(err_miss), 0);
        wait_idle("miss_idle");
        repeat (3) @(negedge clk_sys);
        chk("miss_no_restart", int'(busy), 0);
        @(posedge clk_sys);
        #1;

        // Slot lost during PUSH on an A+B frame: PUSH finishes, LAG, no TAIL, no bus B.
        v = '{2'b11, 2, 4, 14, 0, 1, 1, 0, 15, 1, 0};
        launch(v, 1'b1);
        wait_fire(1, "drop_wait_push");
        @(posedge clk_sys);
        #1;
        slot_open = 1'b0;
        wait_idle("drop_idle");
        slot_open = 1'b1;

`ifdef COMMU_WDOG_EN
        // done_push withheld: watchdog fires on cycle 20 of PUSH and aborts bus B.
        wdog_lim  = 16'd20;
        hold_push = 1'b1;
        v = '{2'b11, 2, 3, 28, 0, 1, 1, 0, 29, 0, 1};
        launch(v, 1'b1);
        wait_idle("wdog_idle");
        chk("wdog_offset", wdog_cyc - push_cyc, 19);
        hold_push = 1'b0;
        wdog_lim  = 16'd0;
`else
        // Without the watchdog a withheld done_push stalls PUSH indefinitely.
        wdog_lim  = 16'd20;
        hold_push = 1'b1;
        v = '{2'b01, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0};
        launch(v, 1'b0);
        wait_fire(1, "nowdog_wait_push");
        repeat (40) @(negedge clk_sys);
        chk("nowdog_busy", int'(busy), 1);
        chk("nowdog_err", fr_wdog, 0);
        chk("nowdog_tail", fr_ft, 0);
        @(posedge clk_sys);
        #1;
        rst_n = 1'b0;
        @(posedge clk_sys);
        #1;
        rst_n     = 1'b1;
        hold_push = 1'b0;
        wdog_lim  = 16'd0;
        @(negedge clk_sys);
        chk("nowdog_reset_busy", int'(busy), 0);
        @(posedge clk_sys);
        #1;
`endif

        // Reset during HEAD: DE drops the next cycle, then a normal frame runs.
        v = '{2'b01, 3, 10, 0, 0, 0, 0, 0, 0, 0, 0};
        launch(v, 1'b0);
        wait_fire(0, "rst_wait_head");
        @(posedge clk_sys);
        #1;
        rst_n = 1'b0;
        @(negedge clk_sys);
        chk("rst_cycle_de_a", int'(de_a), 1);
        @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
        @(negedge clk_sys);
        chk("rst_after_de_a", int'(de_a), 0);
        chk("rst_after_busy", int'(busy), 0);
        repeat (2) @(posedge clk_sys);
        #1;
        v = '{2'b01, 3, 2, 15, 0, 1, 1, 1, 16, 0, 0};
        launch(v, 1'b1);
        wait_idle("post_rst_idle");

        repeat (3) @(negedge clk_sys);
        chk("sb_leftover", sb.size(), 0);
        chk("de_overlap", ovl, 0);
        chk("sel_b_change_with_de", selbad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/commu_txsched.md
COMMU_TXSCHED -- requirements
Module: commu_txsched

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 SHALL have port clk_sys, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 SHALL have port frm_start, input, 1 bit: 1-cycle pulse; a packed frame is buffered and ready to send.
REQ-005 SHALL have port slot_open, input, 1 bit: level; this device's TDMA slot is active.
REQ-006 SHALL have port cfg_bus, input, 2 bits: 01 = A only, 10 = B only, 11 = A then B, 00 = transmit disabled.
REQ-007 SHALL have port guard_cyc, input, 8 bits: DE lead and lag guard time, in clk_sys cycles.
REQ-008 SHALL have port wdog_lim, input, 16 bits: maximum cycles allowed per head/push/tail phase.
REQ-009 SHALL have ports fire_head, fire_push, fire_tail, outputs, 1 bit each: 1-cycle phase start pulses.
REQ-010 SHALL have ports done_head, done_push, done_tail, inputs, 1 bit each: 1-cycle phase completion pulses.
REQ-011 SHALL have ports de_a and de_b, outputs, 1 bit each: RS-485 driver enables for bus A and bus B.
REQ-012 SHALL have port sel_b, output, 1 bit: tx routing select; 0 = bus A, 1 = bus B.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-014 SHALL have ports err_miss and err_wdog, outputs, 1 bit each: 1-cycle error pulses.

Function
REQ-015 SHALL implement states IDLE, WAIT_SLOT, LEAD, HEAD, PUSH, TAIL, LAG and NEXT.
REQ-016 SHALL move IDLE->WAIT_SLOT on frm_start when cfg_bus != 00, and stay in IDLE otherwise.
REQ-017 SHALL move WAIT_SLOT->LEAD on the first cycle slot_open = 1, selecting bus A if cfg_bus[0] = 1, else bus B.
REQ-018 SHALL assert the selected de_x on LEAD entry and count guard_cyc cycles, then enter HEAD; guard_cyc = 0 SHALL give one LEAD cycle.
REQ-019 SHALL issue the fire_x pulse on the first cycle of each of HEAD, PUSH and TAIL, and advance on the matching done_x.
- Sequence: HEAD->PUSH->TAIL->LAG.
- done_x arriving in the same cycle as its fire_x SHALL be accepted.
REQ-020 SHALL hold de_x through LAG for guard_cyc cycles, then deassert it on LAG exit.
REQ-021 SHALL, on LAG exit with cfg_bus = 11 and bus A just used, go through NEXT (1 cycle, sel_b <= 1) to LEAD; otherwise SHALL go to IDLE.
REQ-022 SHALL never assert de_a and de_b in the same cycle.
REQ-023 SHALL change sel_b only while both de_a and de_b are low.
REQ-024 SHALL ignore frm_start while busy = 1 and pulse err_miss in that cycle.
REQ-025 SHALL, if slot_open falls during LEAD/HEAD/PUSH/TAIL, finish the current phase, skip the remaining phases, enter LAG, pulse err_miss, and not start bus B.
REQ-026 SHALL latch cfg_bus and guard_cyc on IDLE->WAIT_SLOT; changes during a frame SHALL have no effect on that frame.
REQ-027 SHALL ignore done_x pulses for phases that are not active.

Reset
REQ-028 SHALL, while rst_n = 0 at a clock edge, set the state to IDLE, all counters to 0, and outputs fire_x, de_a, de_b, sel_b, busy, err_miss and err_wdog to 0.
REQ-029 SHALL apply reset mid-frame within the same cycle, dropping de_x immediately with no lag guard.

Configuration
REQ-030 SHALL, with macro COMMU_WDOG_EN defined, count cycles in each of HEAD/PUSH/TAIL.
- When the count reaches wdog_lim with no done_x: pulse err_wdog, go to LAG, and abort bus B.
- wdog_lim = 0 SHALL disable the watchdog.
REQ-031 SHALL, without COMMU_WDOG_EN, tie err_wdog to 0, ignore wdog_lim, and synthesize no watchdog counter.

Structure
REQ-032 SHALL define in shared package commu_pkg:
- the state encoding;
- cfg_bus encodings (BUS_NONE, BUS_A, BUS_B, BUS_AB);
- width constants GUARD_W = 8 and WDOG_W = 16.
REQ-033 SHALL place the guard counter and watchdog counter in one sub-module, commu_txsched_cnt (load/run/expire), instantiated once.

Verification
REQ-034 SHALL cover: cfg_bus = 01, guard_cyc = 4, slot_open high, done_x 10 cycles after each fire -> de_a high for 4 + 3 phases + 4 cycles, de_b stays 0, busy then returns low.
REQ-035 SHALL cover: cfg_bus = 11 -> complete A sequence, then 1-cycle NEXT with sel_b 0->1 while both DE low, then full B sequence; de_a and de_b never overlap.
REQ-036 SHALL cover: frm_start while slot_open = 0 for 50 cycles -> stays in WAIT_SLOT with no fire; slot_open rises -> LEAD on the next cycle.
REQ-037 SHALL cover: second frm_start during PUSH -> err_miss 1-cycle pulse, the current frame completes unchanged.
REQ-038 SHALL cover: COMMU_WDOG_EN defined, wdog_lim = 20, done_push withheld -> err_wdog pulse at cycle 20 of PUSH, LAG entered, no fire_tail.
REQ-039 SHALL cover: rst_n low during HEAD -> next cycle de_a = 0, busy = 0, state IDLE; a later frm_start runs a normal frame.
